// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg: APB bridge state encoding and default timeout.
package apb_master_bridge_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_e;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/apb_master_bridge_timeout_cnt.sv
// apb_timeout_cnt: counts consecutive stalled ACCESS cycles and flags the LIMIT-th one.
module apb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end
  // expired fires on the stalled cycle that would make the count reach LIMIT
  assign expired = count && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding core-to-APB master bridge.
// Optional ACCESS-phase timeout abort is enabled with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int BUS_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BUS_WIDTH-1:0] M_PADDR,
  output logic                 M_PWRITE,
  output logic                 M_PSELx,
  output logic                 M_PENABLE,
  output logic [BUS_WIDTH-1:0] M_PWDATA,
  input  logic [BUS_WIDTH-1:0] M_PRDATA,
  input  logic                 M_PREADY
);
  apb_state_e state;
  logic timeout;
`ifdef APB_MASTER_TIMEOUT_EN
  logic err;
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ACCESS || M_PREADY),
    .count   (state == ACCESS && !M_PREADY),
    .expired (timeout)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= 1'b0;
    else err <= timeout;
  end
  assign resp_err = err;
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif
  assign req_ready = reset && state == IDLE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      M_PSELx    <= 1'b0;
      M_PENABLE  <= 1'b0;
      M_PWRITE   <= 1'b0;
      M_PADDR    <= '0;
      M_PWDATA   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state    <= SETUP;
          M_PSELx  <= 1'b1;
          M_PADDR  <= req_addr;
          M_PWDATA <= req_wdata;
          M_PWRITE <= req_write;
        end
        SETUP: begin
          state     <= ACCESS;
          M_PENABLE <= 1'b1;
        end
        ACCESS: if (M_PREADY || timeout) begin
          state      <= IDLE;
          M_PSELx    <= 1'b0;
          M_PENABLE  <= 1'b0;
          resp_valid <= 1'b1;
          // stores and aborted transfers return zero data
          resp_rdata <= (M_PWRITE || !M_PREADY) ? '0 : M_PRDATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed stimulus with a transaction-level model checked every cycle.
module tb_apb_master_bridge;
  localparam int W = 16;
  localparam int T = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_write = 1'b0, pready = 1'b0;
  logic [W-1:0] req_addr = '0, req_wdata = '0, prdata = '0;
  logic req_ready, resp_valid, resp_err, pwrite, psel, penable;
  logic [W-1:0] resp_rdata, paddr, pwdata;
  int errors = 0, checks = 0;

  apb_master_bridge #(.BUS_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .M_PADDR(paddr), .M_PWRITE(pwrite), .M_PSELx(psel), .M_PENABLE(penable),
    .M_PWDATA(pwdata), .M_PRDATA(prdata), .M_PREADY(pready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a transfer accepted at edge index a occupies SETUP until edge a+1 and
  // ACCESS from then on; it ends at the first later edge with pready, or when the
  // number of stalled ACCESS cycles (cyc - a - 1) reaches T with the timeout enabled.
  int cyc = 0, m_acc = 0;
  logic m_busy = 1'b0, m_pen = 1'b0, m_wr = 1'b0, m_rv = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic take, abort, done;
  assign take  = !m_busy && req_valid;
  assign abort = TO_EN && m_busy && cyc >= m_acc + 2 && !pready && cyc - m_acc - 1 == T;
  assign done  = m_busy && cyc >= m_acc + 2 && (pready || abort);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_acc <= 0; m_busy <= 1'b0; m_pen <= 1'b0; m_wr <= 1'b0;
      m_rv <= 1'b0; m_err <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else begin
      cyc <= cyc + 1;
      if (take) begin
        m_acc <= cyc; m_addr <= req_addr; m_wdata <= req_wdata; m_wr <= req_write;
      end
      m_busy <= take || (m_busy && !done);
      m_pen  <= m_busy && !done;
      m_rv   <= done;
      m_err  <= abort;
      if (done) m_rdata <= (m_wr || abort) ? '0 : prdata;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, !m_busy && rst_n);
    check("psel", psel, m_busy);
    check("penable", penable, m_pen);
    check("paddr", paddr, m_addr);
    check("pwdata", pwdata, m_wdata);
    check("pwrite", pwrite, m_wr);
    check("resp_valid", resp_valid, m_rv);
    check("resp_err", resp_err, m_err);
    check("resp_rdata", resp_rdata, m_rdata);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic issue(input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_ready", req_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_rdata", resp_rdata, 0);
    rst_n = 1'b1; #1;
    check("ready_after_rst", req_ready, 1);
    // load, zero wait states
    pready = 1'b1; prdata = 16'hBEEF;
    issue(1'b0, 16'h0090, 16'h0000);
    check("ld_setup_psel", psel, 1);
    check("ld_setup_pen", penable, 0);
    check("ld_paddr", paddr, 16'h0090);
    tick(); check("ld_access_pen", penable, 1);
    tick();
    check("ld_resp", resp_valid, 1);
    check("ld_rdata", resp_rdata, 16'hBEEF);
    check("ld_psel_off", psel, 0);
    tick();
    check("ld_pulse_once", resp_valid, 0);
    check("ld_rdata_hold", resp_rdata, 16'hBEEF);
    // store with three stalled ACCESS cycles
    pready = 1'b0; prdata = 16'hDEAD;
    issue(1'b1, 16'h00A0, 16'h1234);
    tick(3);
    check("st_paddr", paddr, 16'h00A0);
    check("st_pwdata", pwdata, 16'h1234);
    check("st_pwrite", pwrite, 1);
    check("st_no_resp", resp_valid, 0);
    tick(); pready = 1'b1;
    check("st_last_access", penable, 1);
    tick();
    check("st_resp", resp_valid, 1);
    check("st_rdata", resp_rdata, 16'h0000);
    // back-to-back loads with req_valid held high
    prdata = 16'h1111; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    tick(); req_addr = 16'h0020;
    tick(); check("b2b_paddr_stable", paddr, 16'h0010);
    tick();
    check("b2b_resp1", resp_valid, 1);
    check("b2b_rdata1", resp_rdata, 16'h1111);
    check("b2b_ready", req_ready, 1);
    prdata = 16'h2222;
    tick(); req_valid = 1'b0;
    check("b2b_setup2_psel", psel, 1);
    check("b2b_setup2_pen", penable, 0);
    check("b2b_paddr2", paddr, 16'h0020);
    tick(2);
    check("b2b_resp2", resp_valid, 1);
    check("b2b_rdata2", resp_rdata, 16'h2222);
    // reset in the middle of ACCESS
    pready = 1'b0;
    issue(1'b1, 16'h0055, 16'h7777);
    tick();
    #1 rst_n = 1'b0; #1;
    check("arst_psel", psel, 0);
    check("arst_pen", penable, 0);
    check("arst_paddr", paddr, 0);
    check("arst_ready", req_ready, 0);
    pready = 1'b1;
    tick(); rst_n = 1'b1; #1;
    check("arst_ready_release", req_ready, 1);
    tick(); check("arst_no_resp", resp_valid, 0);
`ifdef APB_MASTER_TIMEOUT_EN
    pready = 1'b0; prdata = 16'h5A5A;
    issue(1'b0, 16'h0033, 16'h0000);
    tick(4); check("to_no_resp_yet", resp_valid, 0);
    tick();
    check("to_valid", resp_valid, 1);
    check("to_err", resp_err, 1);
    check("to_rdata", resp_rdata, 0);
    check("to_psel", psel, 0);
    tick(); check("to_err_pulse", resp_err, 0);
    prdata = 16'hCAFE;
    issue(1'b0, 16'h0044, 16'h0000);
    tick(4); pready = 1'b1;
    tick();
    check("to_late_valid", resp_valid, 1);
    check("to_late_err", resp_err, 0);
    check("to_late_rdata", resp_rdata, 16'hCAFE);
`else
    pready = 1'b0;
    issue(1'b0, 16'h0033, 16'h0000);
    tick(10);
    check("wait_psel", psel, 1);
    check("wait_pen", penable, 1);
    check("wait_no_resp", resp_valid, 0);
    pready = 1'b1; prdata = 16'hCAFE;
    tick();
    check("wait_resp", resp_valid, 1);
    check("wait_err", resp_err, 0);
    check("wait_rdata", resp_rdata, 16'hCAFE);
`endif
    pready = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, address and data width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (used only with the timeout feature).
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 Ports: clk  in  1  clock; reset  in  1  asynchronous active-low reset.
REQ-005 Ports: req_valid  in  1  core request; req_ready  out  1  bridge can accept; req_write  in  1  1=store, 0=load.
REQ-006 Ports: req_addr  in  BUS_WIDTH  address; req_wdata  in  BUS_WIDTH  store data.
REQ-007 Ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  BUS_WIDTH  load data; resp_err  out  1  timeout abort.
REQ-008 Ports: M_PADDR  out  BUS_WIDTH; M_PWRITE  out  1; M_PSELx  out  1; M_PENABLE  out  1; M_PWDATA  out  BUS_WIDTH.
REQ-009 Ports: M_PRDATA  in  BUS_WIDTH; M_PREADY  in  1.

Function
REQ-010 SHALL implement the FSM states IDLE, SETUP and ACCESS, with the state held in a register.
REQ-011 req_ready SHALL be 1 exactly when the state is IDLE and reset is deasserted.
REQ-012 req_valid && req_ready at edge N SHALL capture addr, write and wdata into registers and enter SETUP at N+1.
REQ-013 SETUP SHALL drive M_PSELx=1 and M_PENABLE=0, then unconditionally enter ACCESS on the next edge.
REQ-014 ACCESS SHALL drive M_PSELx=1 and M_PENABLE=1, and remain in ACCESS while M_PREADY=0.
REQ-015 M_PADDR, M_PWRITE and M_PWDATA SHALL equal the captured values and stay stable throughout SETUP and ACCESS.
REQ-016 In IDLE, M_PADDR, M_PWDATA and M_PWRITE SHALL hold their last values, and M_PSELx and M_PENABLE SHALL be 0.
REQ-017 M_PREADY=1 sampled in ACCESS at edge K SHALL cause resp_valid=1 for exactly cycle K+1, with a return to IDLE at K+1.
REQ-018 On a load completion, resp_rdata SHALL register M_PRDATA sampled at edge K.
REQ-019 On a store completion, resp_rdata SHALL be 0.
REQ-020 Minimum latency SHALL be: accept at N, resp_valid at N+3.
REQ-021 Back-to-back requests SHALL be allowed: a request accepted in the resp_valid cycle K+1 enters SETUP at K+2.
REQ-022 M_PREADY SHALL be ignored outside ACCESS.
REQ-023 req_valid SHALL be ignored outside IDLE.
REQ-024 resp_rdata SHALL hold its value until the next completion.

Reset
REQ-025 Asserting reset SHALL force IDLE asynchronously, from any state including mid-ACCESS.
REQ-026 During reset, req_ready, resp_valid, resp_err, M_PSELx, M_PENABLE and M_PWRITE SHALL be 0.
REQ-027 During reset, resp_rdata, M_PADDR and M_PWDATA SHALL be 0.
REQ-028 A transfer interrupted by reset SHALL be dropped with no response.

Configuration
REQ-029 Macro APB_MASTER_TIMEOUT_EN, when defined, SHALL count consecutive ACCESS cycles with M_PREADY=0.
REQ-030 With the macro defined, reaching TIMEOUT_CYCLES SHALL abort the transfer: resp_valid=1, resp_err=1, resp_rdata=0 in the next cycle, PSEL/PENABLE deasserted, state IDLE.
REQ-031 With the macro defined, M_PREADY=1 on the same edge the count reaches TIMEOUT_CYCLES SHALL complete normally, with resp_err=0.
REQ-032 Without the macro, resp_err SHALL be tied 0, no counter SHALL exist, and ACCESS SHALL wait indefinitely.

Structure
REQ-033 State encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the default TIMEOUT_CYCLES SHALL live in the shared vmicro16 APB definitions package/include.
REQ-034 The timeout counter SHALL be sub-module apb_timeout_cnt (inputs clk, reset, clear, count; output expired), instantiated only under APB_MASTER_TIMEOUT_EN.

Verification
REQ-035 Load at 16'h0090 with M_PREADY tied 1 and M_PRDATA=16'hBEEF -> PSEL at N+1, PENABLE at N+2, resp_valid with rdata 16'hBEEF at N+3.
REQ-036 Store 16'h1234 to 16'h00A0 with M_PREADY low for 3 ACCESS cycles -> PWDATA/PADDR/PWRITE stable throughout; resp_valid at N+6 with rdata 0.
REQ-037 Two back-to-back loads with req_valid held high -> second SETUP in the cycle after the first resp_valid; no idle cycle lost.
REQ-038 reset asserted mid-ACCESS -> PSEL/PENABLE 0 immediately (asynchronous), no resp_valid, and req_ready 1 on the first cycle after release.
REQ-039 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4 and M_PREADY stuck 0 -> resp_valid=1, resp_err=1 after 4 ACCESS cycles, then IDLE.
REQ-040 With APB_MASTER_TIMEOUT_EN, M_PREADY rising on the 4th ACCESS cycle -> resp_err=0 and valid data returned.
